// File: rtl/ysyx_24080006_pkg.sv
// Shared types and geometry for the instruction cache and its AXI4 read port.
// Line size and set count are fixed here; the cache module derives everything from them.
package ysyx_24080006_pkg;

   localparam int IC_M     = 5;
   localparam int IC_N     = 5;
   localparam int IC_WORDS = 1 << (IC_M - 2);
   localparam int IC_SETS  = 1 << IC_N;
   localparam int IC_OFF_W = IC_M - 2;
   localparam int IC_TAG_W = 32 - IC_M - IC_N;

   typedef enum logic [1:0] {IC_IDLE, IC_LOOKUP, IC_AR, IC_R} icache_state_e;

   typedef struct packed {
      logic                     valid;
      logic [IC_TAG_W-1:0]      tag;
      logic [IC_WORDS*32-1:0]   data;
   } icache_t;

   typedef struct packed {
      logic        arvalid;
      logic [31:0] araddr;
      logic [7:0]  arlen;
      logic [2:0]  arsize;
      logic [1:0]  arburst;
      logic        rready;
   } axi_r_m2s_t;

   typedef struct packed {
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        rlast;
   } axi_r_s2m_t;

endpackage

// File: rtl/ysyx_24080006_icache.sv
// Direct-mapped instruction cache: one word per fetch, whole-line refill via a single
// INCR burst, and fence.i invalidation (deferred to the end of an in-flight refill).
module ysyx_24080006_icache
   import ysyx_24080006_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_valid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_ready,
   output logic        inst_valid,
   output logic [31:0] inst,
   input  logic        fence_i,
   output axi_r_m2s_t  axi_r_m2s,
   input  axi_r_s2m_t  axi_r_s2m
);

   icache_state_e         state_reg, state_next;
   logic [31:0]           addr_reg;
   logic [IC_OFF_W-1:0]   cnt_reg;
   logic                  fence_pend_reg;

   logic                  valid_reg [IC_SETS];
   logic [IC_TAG_W-1:0]   tag_reg   [IC_SETS];
   logic [IC_WORDS*32-1:0] data_reg [IC_SETS];
   logic [31:0]           buf_reg   [IC_WORDS-1];

   logic [IC_N-1:0]       index;
   logic [IC_TAG_W-1:0]   tag;
   logic [IC_OFF_W-1:0]   off;
   icache_t               line;
   logic [IC_WORDS*32-1:0] fill_data;
   logic                  hit, beat, last_beat, clear_all;
   logic                  unused_bits;

   assign index = addr_reg[IC_M+IC_N-1:IC_M];
   assign tag   = addr_reg[31:IC_M+IC_N];
   assign off   = addr_reg[IC_M-1:2];
   assign line  = '{valid: valid_reg[index], tag: tag_reg[index], data: data_reg[index]};
   assign hit   = line.valid && (line.tag == tag);

   assign beat      = (state_reg == IC_R) && axi_r_s2m.rvalid;
   assign last_beat = beat && (cnt_reg == IC_OFF_W'(IC_WORDS - 1));
   // A fence seen mid-refill is honoured only once the pending request has been served.
   assign clear_all = (fence_i && (state_reg == IC_IDLE || state_reg == IC_LOOKUP))
                   || (state_reg == IC_LOOKUP && hit && fence_pend_reg);

   assign unused_bits = ^{addr_reg[1:0], axi_r_s2m.rresp};

   // The last beat bypasses the buffer straight into the array write.
   generate
      for (genvar gi = 0; gi < IC_WORDS - 1; gi++) begin : g_fill
         assign fill_data[32*gi +: 32] = buf_reg[gi];
      end
   endgenerate
   assign fill_data[32*(IC_WORDS-1) +: 32] = axi_r_s2m.rdata;

   always_comb begin
      state_next = state_reg;
      ifu_ready  = 1'b0;
      inst_valid = 1'b0;
      inst       = '0;
      axi_r_m2s  = '0;
      axi_r_m2s.araddr  = {addr_reg[31:IC_M], {IC_M{1'b0}}};
      axi_r_m2s.arlen   = 8'(IC_WORDS - 1);
      axi_r_m2s.arsize  = 3'b010;
      axi_r_m2s.arburst = 2'b01;
      case (state_reg)
         IC_IDLE: begin
            ifu_ready = 1'b1;
            if (ifu_valid) state_next = IC_LOOKUP;
         end
         IC_LOOKUP: begin
            if (hit) begin
               inst_valid = 1'b1;
               inst       = line.data[32*off +: 32];
               state_next = IC_IDLE;
            end else begin
               state_next = IC_AR;
            end
         end
         IC_AR: begin
            axi_r_m2s.arvalid = 1'b1;
            if (axi_r_s2m.arready) state_next = IC_R;
         end
         IC_R: begin
            axi_r_m2s.rready = 1'b1;
            if (last_beat) state_next = IC_LOOKUP;
         end
         default: state_next = IC_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IC_IDLE;
         addr_reg       <= '0;
         cnt_reg        <= '0;
         fence_pend_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IC_IDLE && ifu_valid) addr_reg <= ifu_addr;
         if (state_reg == IC_AR && axi_r_s2m.arready) cnt_reg <= '0;
         else if (beat)                               cnt_reg <= cnt_reg + 1'b1;
         if (fence_i && (state_reg == IC_AR || state_reg == IC_R)) fence_pend_reg <= 1'b1;
         else if (state_reg == IC_LOOKUP && hit)                   fence_pend_reg <= 1'b0;
      end
   end

   generate
      for (genvar gi = 0; gi < IC_SETS; gi++) begin : g_valid
         always_ff @(posedge clock or posedge reset) begin
            if (reset)                                 valid_reg[gi] <= 1'b0;
            else if (clear_all)                        valid_reg[gi] <= 1'b0;
            else if (last_beat && index == IC_N'(gi))  valid_reg[gi] <= 1'b1;
         end
      end
   endgenerate

   // Tag, data and refill buffer carry no reset; the valid bits guard them.
   always_ff @(posedge clock) begin
      if (beat && !last_beat) buf_reg[cnt_reg] <= axi_r_s2m.rdata;
      if (last_beat) begin
         tag_reg[index]  <= tag;
         data_reg[index] <= fill_data;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!reset && beat) assert (axi_r_s2m.rlast == (cnt_reg == IC_OFF_W'(IC_WORDS - 1)));
   end
`endif

endmodule

// File: tb/tb_ysyx_24080006_icache.sv
// Directed bench for the icache: AXI slave model, queue scoreboard and a negedge monitor.
// Line 0x3000_0000 holds 0x11..0x88; every other word holds its address ^ 0xA5A5_0000.
module tb_ysyx_24080006_icache;
   import ysyx_24080006_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ifu_valid = 1'b0;
   logic [31:0] ifu_addr = '0;
   logic        fence_i = 1'b0;
   logic        ifu_ready, inst_valid;
   logic [31:0] inst;
   axi_r_m2s_t  m2s;
   axi_r_s2m_t  s2m;

   int checks = 0;
   int failures = 0;
   int ar_count = 0;
   int lat;
   logic [31:0] inst_q[$];
   logic [31:0] ar_q[$];

   logic        s_arready, s_rvalid, s_rlast, s_busy;
   logic [31:0] s_rdata, s_line;
   int          s_beat, ar_wait;
   int          ar_delay = 0;
   logic        prev_pend;
   logic [31:0] prev_addr;

   ysyx_24080006_icache dut (
      .clock(clock), .reset(reset), .ifu_valid(ifu_valid), .ifu_addr(ifu_addr),
      .ifu_ready(ifu_ready), .inst_valid(inst_valid), .inst(inst), .fence_i(fence_i),
      .axi_r_m2s(m2s), .axi_r_s2m(s2m)
   );

   always #5 clock = ~clock;

   assign s2m = '{arready: s_arready, rvalid: s_rvalid, rdata: s_rdata, rresp: 2'b00, rlast: s_rlast};

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a[31:5] == 27'h180_0000) return 32'h11 * ({29'd0, a[4:2]} + 32'd1);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // Slave: arready after ar_delay extra cycles, then 8 zero-wait beats.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         s_arready <= 1'b0; s_rvalid <= 1'b0; s_rlast <= 1'b0; s_busy <= 1'b0;
         s_rdata <= '0; s_line <= '0; s_beat <= 0; ar_wait <= 0;
      end else if (!s_busy) begin
         if (m2s.arvalid && s_arready) begin
            s_arready <= 1'b0; ar_wait <= 0; s_busy <= 1'b1; s_line <= m2s.araddr;
            s_beat <= 0; s_rvalid <= 1'b1; s_rdata <= mem_word(m2s.araddr); s_rlast <= 1'b0;
         end else if (m2s.arvalid) begin
            if (ar_wait >= ar_delay) s_arready <= 1'b1;
            else                     ar_wait <= ar_wait + 1;
         end
      end else if (s_rvalid && m2s.rready) begin
         s_beat <= s_beat + 1;
         if (s_beat == 7) begin
            s_rvalid <= 1'b0; s_busy <= 1'b0; s_rlast <= 1'b0;
         end else begin
            s_rdata <= mem_word(s_line + 32'((s_beat + 1) * 4));
            s_rlast <= (s_beat + 1 == 7);
         end
      end
   end

   // Monitor: pops the scoreboards whenever the DUT presents an instruction or an AR handshake.
   always @(negedge clock) begin
      if (reset) begin
         prev_pend = 1'b0;
      end else begin
         if (inst_valid) begin
            if (inst_q.size() == 0) fail("unexpected_inst");
            else check("inst", inst, inst_q.pop_front());
         end
         if (prev_pend) begin
            check("ar_hold_valid", {31'd0, m2s.arvalid}, 32'd1);
            check("ar_hold_addr", m2s.araddr, prev_addr);
            check("ar_hold_len", {24'd0, m2s.arlen}, 32'd7);
         end
         if (m2s.arvalid && s_arready) begin
            ar_count++;
            if (ar_q.size() == 0) fail("unexpected_ar");
            else check("araddr", m2s.araddr, ar_q.pop_front());
            check("arlen", {24'd0, m2s.arlen}, 32'd7);
            check("arsize", {29'd0, m2s.arsize}, 32'd2);
            check("arburst", {30'd0, m2s.arburst}, 32'd1);
         end
         prev_pend = m2s.arvalid && !s_arready;
         prev_addr = m2s.araddr;
      end
   end

   task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input bit miss, output int cyc);
      int n;
      @(negedge clock);
      ifu_valid = 1'b1;
      ifu_addr  = a;
      inst_q.push_back(exp);
      if (miss) ar_q.push_back({a[31:5], 5'b0});
      n = 0;
      while (!ifu_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!ifu_ready) fail("accept_timeout");
      @(posedge clock);
      #1 ifu_valid = 1'b0;
      cyc = 0;
      while (cyc < 200) begin
         @(negedge clock);
         cyc++;
         if (inst_valid) break;
      end
      if (!inst_valid) fail("inst_timeout");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      check("rst_arvalid", {31'd0, m2s.arvalid}, 32'd0);
      check("rst_rready", {31'd0, m2s.rready}, 32'd0);
      check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      check("rst_inst", inst, 32'd0);
      reset = 1'b0;
      #1 check("rst_ifu_ready", {31'd0, ifu_ready}, 32'd1);

      // 1 cold miss, inst one cycle after the 8th beat
      fetch(32'h3000_0000, 32'h0000_0011, 1, lat);
      check("miss_latency", lat, 12);
      // 2 hit, no AR
      fetch(32'h3000_0014, 32'h0000_0066, 0, lat);
      check("hit_latency", lat, 1);
      check("hit_no_ar", ar_count, 1);
      // 3 conflict on set 0
      fetch(32'h3000_0408, 32'h95A5_0408, 1, lat);
      fetch(32'h3000_0000, 32'h0000_0011, 1, lat);
      // 4 fence in idle
      @(negedge clock) fence_i = 1'b1;
      @(negedge clock) fence_i = 1'b0;
      fetch(32'h3000_001C, 32'h0000_0088, 1, lat);
      // 5 fence during beat 3 of a refill
      fork
         fetch(32'h3000_0044, 32'h95A5_0044, 1, lat);
         begin : fence_mid_r
            int n;
            n = 0;
            while (!(s_busy && s_beat == 3) && n < 100) begin
               @(negedge clock);
               n++;
            end
            if (n >= 100) fail("fence_beat_timeout");
            fence_i = 1'b1;
            @(negedge clock) fence_i = 1'b0;
         end
      join
      fetch(32'h3000_0048, 32'h95A5_0048, 1, lat);
      // 6 AR backpressure; line 0 was invalidated by the deferred fence
      ar_delay = 5;
      fetch(32'h3000_0004, 32'h0000_0022, 1, lat);
      ar_delay = 0;
      fetch(32'h3000_000C, 32'h0000_0044, 0, lat);
      check("hit_latency2", lat, 1);

      // reset in the middle of a burst
      @(negedge clock);
      ifu_valid = 1'b1;
      ifu_addr  = 32'h3000_0080;
      ar_q.push_back(32'h3000_0080);
      @(posedge clock);
      #1 ifu_valid = 1'b0;
      begin : wait_beat3
         int n;
         n = 0;
         while (!(s_busy && s_beat == 3) && n < 100) begin
            @(negedge clock);
            n++;
         end
         if (n >= 100) fail("reset_beat_timeout");
      end
      reset = 1'b1;
      #1;
      check("midr_arvalid", {31'd0, m2s.arvalid}, 32'd0);
      check("midr_rready", {31'd0, m2s.rready}, 32'd0);
      check("midr_inst_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clock) reset = 1'b0;
      #1 check("post_rst_ready", {31'd0, ifu_ready}, 32'd1);
      fetch(32'h3000_000C, 32'h0000_0044, 1, lat);

      repeat (3) @(negedge clock);
      check("inst_q_empty", inst_q.size(), 0);
      check("ar_q_empty", ar_q.size(), 0);
      check("ar_total", ar_count, 9);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
